// File: rtl/snake_pkg.sv
// Shared encodings for the snake game controller: headings, FSM states and
// the opposite-heading helper used by the turn-reversal check.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_OVER  = 3'd3,
      ST_WIN   = 3'd4
   } state_e;

   // Left/right and up/down differ only in bit 0.
   function automatic logic [1:0] opposite_dir(input logic [1:0] d);
      return {d[1], ~d[0]};
   endfunction

endpackage

// File: rtl/snake_dir_queue.sv
// Two-entry turn-request FIFO; a request is dropped when it repeats or reverses
// the heading it would follow, or when there is no room after this cycle's pop.
module snake_dir_queue
   import snake_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clear,
   input  logic       i_push,
   input  logic [1:0] i_push_dir,
   input  logic       i_pop,
   input  logic [1:0] i_cur_dir,
   output logic [1:0] o_head,
   output logic [1:0] o_tail,
   output logic       o_full,
   output logic       o_empty
);

   logic [1:0] r_q [2];
   logic [1:0] r_cnt;
   logic [1:0] w_q_nxt [2];
   logic [1:0] w_cnt_nxt;
   logic [1:0] w_cnt_pop;
   logic [1:0] w_ref;
   logic       w_pop_do;
   logic       w_push_ok;

   assign o_empty = (r_cnt == 2'd0);
   assign o_full  = (r_cnt == 2'd2);
   assign o_head  = r_q[0];
   assign o_tail  = o_full ? r_q[1] : r_q[0];

   // The post-pop reference heading equals the pre-pop tail (or dir_o when empty),
   // so the reversal check needs no pop-dependent mux.
   assign w_ref     = o_empty ? i_cur_dir : o_tail;
   assign w_pop_do  = i_pop && !o_empty;
   assign w_cnt_pop = w_pop_do ? (r_cnt - 2'd1) : r_cnt;
   assign w_push_ok = i_push && (i_push_dir != w_ref)
                      && (i_push_dir != opposite_dir(w_ref)) && (w_cnt_pop != 2'd2);

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_q_nxt   = r_q;
      w_cnt_nxt = w_cnt_pop;
      if (w_pop_do) begin
         w_q_nxt[0] = r_q[1];
      end
      if (w_push_ok) begin
         w_q_nxt[w_cnt_pop[0]] = i_push_dir;
         w_cnt_nxt             = w_cnt_pop + 2'd1;
      end
      if (i_clear) begin
         w_cnt_nxt = 2'd0;
      end
   end

   // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
   // NOTE: the storage is only four bits, so it is reset too and never shows X on o_head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q   <= '{default: 2'd0};
         r_cnt <= 2'd0;
      end else begin
         r_q   <= w_q_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: state machine, step timer and turn queue in front of gamelogic.
// Define SNAKE_CTRL_SPEEDUP_EN to shorten the step period as the score rises.
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int unsigned BASE_PERIOD = 25_000_000,
   parameter int unsigned MIN_PERIOD  = 5_000_000,
   parameter int unsigned PERIOD_DEC  = 2_000_000,
   parameter int unsigned SCORE_DIV   = 3
)(
   input  logic       master_clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       pause_i,
   input  logic [3:0] btn_i,
   input  logic [9:0] score_i,
   input  logic       won_i,
   input  logic       lost_i,
   output logic       game_rst_o,
   output logic       step_o,
   output logic [1:0] dir_o,
   output logic [2:0] state_o
);

   state_e      r_state, w_state_nxt;
   logic        w_start, w_end, w_run, w_wrap, w_push;
   logic        r_step, r_game_rst;
   logic [1:0]  r_dir, w_btn_dir;
   logic [31:0] r_cnt, r_period, w_period_calc;
   logic        w_q_empty, w_q_full;
   logic [1:0]  w_q_head, w_q_tail;
   logic        w_q_status_unused;

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_end       = 1'b0;
      case (r_state)
         ST_IDLE, ST_OVER, ST_WIN: begin
            if (start_i) begin
               w_state_nxt = ST_RUN;
               w_start     = 1'b1;
            end
         end
         ST_RUN: begin
            if (lost_i) begin
               w_state_nxt = ST_OVER;
               w_end       = 1'b1;
            end else if (won_i) begin
               w_state_nxt = ST_WIN;
               w_end       = 1'b1;
            end else if (pause_i) begin
               w_state_nxt = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (pause_i) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge master_clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   assign w_run  = (r_state == ST_RUN);
   assign w_wrap = w_run && !w_end && (r_cnt == r_period - 32'd1);
   assign w_push = w_run && (|btn_i);

   // Lowest set bit wins: left > right > up > down.
   always_comb begin
      w_btn_dir = DIR_DOWN;
      if (btn_i[2]) w_btn_dir = DIR_UP;
      if (btn_i[1]) w_btn_dir = DIR_RIGHT;
      if (btn_i[0]) w_btn_dir = DIR_LEFT;
   end

`ifdef SNAKE_CTRL_SPEEDUP_EN
   logic [31:0] w_band, w_dec;
   assign w_band        = {22'd0, score_i} / SCORE_DIV;
   assign w_dec         = w_band * PERIOD_DEC;
   assign w_period_calc = ((w_dec >= BASE_PERIOD) || ((BASE_PERIOD - w_dec) < MIN_PERIOD))
                          ? MIN_PERIOD : (BASE_PERIOD - w_dec);
`else
   logic w_score_unused;
   assign w_score_unused = ^score_i;
   assign w_period_calc  = BASE_PERIOD;
`endif

   always_ff @(posedge master_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= 32'd0;
         r_period   <= BASE_PERIOD;
         r_dir      <= DIR_RIGHT;
         r_step     <= 1'b0;
         r_game_rst <= 1'b0;
      end else begin
         r_step     <= w_wrap;
         r_game_rst <= w_start;
         if (w_start) begin
            r_cnt    <= 32'd0;
            r_period <= BASE_PERIOD;
            r_dir    <= DIR_RIGHT;
         end else if (w_wrap) begin
            r_cnt    <= 32'd0;
            r_period <= w_period_calc;
            if (!w_q_empty) r_dir <= w_q_head;
         end else if (w_run && !w_end) begin
            r_cnt <= r_cnt + 32'd1;
         end
      end
   end

   snake_dir_queue u_dir_queue (
      .clk        (master_clk),
      .rst_n      (rst_n),
      .i_clear    (w_start),
      .i_push     (w_push),
      .i_push_dir (w_btn_dir),
      .i_pop      (w_wrap),
      .i_cur_dir  (r_dir),
      .o_head     (w_q_head),
      .o_tail     (w_q_tail),
      .o_full     (w_q_full),
      .o_empty    (w_q_empty)
   );

   assign w_q_status_unused = ^{w_q_full, w_q_tail};

   assign game_rst_o = r_game_rst;
   assign step_o     = r_step;
   assign dir_o      = r_dir;
   assign state_o    = r_state;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios plus random stimulus against a queue-based model.
module tb_snake_game_ctrl;

   localparam int BASE = 10;
   localparam int MINP = 4;
   localparam int DEC  = 2;
   localparam int DIV  = 3;

   logic       master_clk = 1'b0;
   logic       rst_n      = 1'b0;
   logic       start_i    = 1'b0;
   logic       pause_i    = 1'b0;
   logic       won_i      = 1'b0;
   logic       lost_i     = 1'b0;
   logic [3:0] btn_i      = 4'd0;
   logic [9:0] score_i    = 10'd0;
   logic       game_rst_o, step_o;
   logic [1:0] dir_o;
   logic [2:0] state_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: game state, heading, cycles since last step, period, queued turns.
   int m_state, m_dir, m_cnt, m_per;
   bit m_step, m_grst;
   int q[$];

   snake_game_ctrl #(
      .BASE_PERIOD (BASE),
      .MIN_PERIOD  (MINP),
      .PERIOD_DEC  (DEC),
      .SCORE_DIV   (DIV)
   ) dut (
      .master_clk (master_clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .pause_i    (pause_i),
      .btn_i      (btn_i),
      .score_i    (score_i),
      .won_i      (won_i),
      .lost_i     (lost_i),
      .game_rst_o (game_rst_o),
      .step_o     (step_o),
      .dir_o      (dir_o),
      .state_o    (state_o)
   );

   always #5 master_clk = ~master_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_dir = 1; m_cnt = 0; m_per = BASE;
      m_step = 0; m_grst = 0;
      q.delete();
   endtask

   task automatic model_update();
      int d, r;
      m_step = 0;
      m_grst = 0;
      case (m_state)
         0, 3, 4: if (start_i) begin
            m_state = 1; m_grst = 1; q.delete();
            m_dir = 1; m_cnt = 0; m_per = BASE;
         end
         1: begin
            if (lost_i) m_state = 3;
            else if (won_i) m_state = 4;
            else begin
               if (m_cnt == m_per - 1) begin
                  m_cnt  = 0;
                  m_step = 1;
                  if (q.size() > 0) m_dir = q.pop_front();
`ifdef SNAKE_CTRL_SPEEDUP_EN
                  m_per = BASE - (int'(score_i) / DIV) * DEC;
                  if (m_per < MINP) m_per = MINP;
`endif
               end else begin
                  m_cnt++;
               end
               if (pause_i) m_state = 2;
            end
            if (btn_i != 4'd0) begin
               d = btn_i[0] ? 0 : btn_i[1] ? 1 : btn_i[2] ? 2 : 3;
               r = (q.size() > 0) ? q[$] : m_dir;
               if (d != r && d != (r ^ 1) && q.size() < 2) q.push_back(d);
            end
         end
         2: if (pause_i) m_state = 1;
         default: ;
      endcase
   endtask

   // One clock: model follows the edge, outputs are compared 1 time unit later.
   task automatic cyc();
      @(posedge master_clk);
      model_update();
      #1;
      check("state", state_o, m_state);
      check("dir", dir_o, m_dir);
      check("step", step_o, m_step);
      check("game_rst", game_rst_o, m_grst);
      start_i = 1'b0;
      pause_i = 1'b0;
      btn_i   = 4'd0;
   endtask

   task automatic wait_step(input int budget, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (step_o !== 1'b1 && n < budget);
   endtask

   initial begin
      int n, steps, exp6, exp4;
`ifdef SNAKE_CTRL_SPEEDUP_EN
      exp6 = 6; exp4 = 4;
`else
      exp6 = 10; exp4 = 10;
`endif
      model_reset();
      repeat (3) @(posedge master_clk);
      #1;
      check("rst_state", state_o, 0);
      check("rst_dir", dir_o, 1);
      check("rst_step", step_o, 0);
      check("rst_game_rst", game_rst_o, 0);
      rst_n = 1'b1;
      cyc(); cyc();

      // Reset and start
      start_i = 1'b1; cyc();
      check("start_state", state_o, 1);
      check("start_game_rst", game_rst_o, 1);
      wait_step(40, n);
      check("first_step_latency", n, 10);
      wait_step(40, n);
      check("step_spacing", n, 10);

      // Reversal rejection and full-queue drop
      btn_i = 4'b0001; cyc();
      wait_step(40, n);
      check("reverse_rejected_dir", dir_o, 1);
      btn_i = 4'b0100; cyc();
      btn_i = 4'b0001; cyc();
      btn_i = 4'b1000; cyc();
      wait_step(40, n);
      check("queue_step1_dir", dir_o, 2);
      wait_step(40, n);
      check("queue_step2_dir", dir_o, 0);
      wait_step(40, n);
      check("full_drop_dir", dir_o, 0);

      // Pause at counter 6 for 20 cycles
      repeat (6) cyc();
      pause_i = 1'b1; cyc();
      check("pause_state", state_o, 2);
      steps = 0;
      repeat (19) begin
         cyc();
         if (step_o) steps++;
      end
      check("no_step_in_pause", steps, 0);
      pause_i = 1'b1; cyc();
      check("resume_state", state_o, 1);
      wait_step(40, n);
      check("resume_step_latency", n, 3);

      // Game end on the wrap cycle
      repeat (9) cyc();
      lost_i = 1'b1; won_i = 1'b1; cyc();
      check("over_state", state_o, 3);
      check("over_no_step", step_o, 0);
      lost_i = 1'b0; won_i = 1'b0;
      cyc();
      start_i = 1'b1; cyc();
      check("restart_state", state_o, 1);
      check("restart_game_rst", game_rst_o, 1);

      // Speed-up
      score_i = 10'd6;
      wait_step(40, n);
      check("speed_first", n, 10);
      wait_step(40, n);
      check("speed_score6", n, exp6);
      score_i = 10'd30;
      wait_step(40, n);
      check("speed_prev_period", n, exp6);
      wait_step(40, n);
      check("speed_score30", n, exp4);

      // Random stimulus against the model
      repeat (400) begin
         start_i = ($urandom_range(0, 39) == 0);
         pause_i = ($urandom_range(0, 29) == 0);
         btn_i   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
         lost_i  = ($urandom_range(0, 99) == 0);
         won_i   = ($urandom_range(0, 99) == 0);
         score_i = 10'($urandom_range(0, 40));
         cyc();
      end
      lost_i = 1'b0; won_i = 1'b0; score_i = 10'd0;

      // Async reset mid-game with two queued turns
      #2 rst_n = 1'b0;
      @(posedge master_clk);
      #1 rst_n = 1'b1;
      model_reset();
      start_i = 1'b1; cyc();
      btn_i = 4'b0100; cyc();
      btn_i = 4'b0001; cyc();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_state", state_o, 0);
      check("async_rst_dir", dir_o, 1);
      check("async_rst_step", step_o, 0);
      @(posedge master_clk);
      #1 rst_n = 1'b1;
      model_reset();
      steps = 0;
      repeat (15) begin
         cyc();
         if (step_o) steps++;
      end
      check("no_step_after_rst", steps, 0);
      start_i = 1'b1; cyc();
      wait_step(40, n);
      check("post_rst_step_latency", n, 10);
      check("post_rst_queue_empty_dir", dir_o, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
